// File: rtl/lim_counter_chain_if.sv
// Bus bundle for lim_counter_chain: step/load controls in, packed count and status out.
interface lim_counter_chain_if #(
  parameter int NDIG = 4,
  parameter int DW   = 4
);
  logic                 en;
  logic                 tick;
  logic                 dir;
  logic                 wrap;
  logic                 load;
  logic [NDIG*DW-1:0]   load_val;
  logic [NDIG*DW-1:0]   count;
  logic                 co;
  logic                 at_term;

  modport master (
    output en, tick, dir, wrap, load, load_val,
    input  count, co, at_term
  );

  modport slave (
    input  en, tick, dir, wrap, load, load_val,
    output count, co, at_term
  );
endinterface

// File: rtl/lim_counter_chain.sv
// Cascaded chain of NDIG limited up/down digits with wrap/saturate and clamped load.
// Optional step prescaler enabled by defining LCC_PRESCALE_EN.
module lim_counter_chain #(
  parameter int                      NDIG     = 4,
  parameter int                      DW       = 4,
  parameter logic [NDIG*DW-1:0]      LIMS     = 16'h5959,
  parameter int                      PRESCALE = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  lim_counter_chain_if.slave   bus
);

  localparam int W = NDIG * DW;

  if (PRESCALE < 1) begin : g_bad_prescale
    $error("lim_counter_chain: PRESCALE must be >= 1");
  end

  logic [W-1:0]  count_q;
  logic          co_q;
  logic [W-1:0]  step_val;
  logic [W-1:0]  load_clamped;
  logic [NDIG:0] adv;
  logic          carry_out;
  logic          qual;
  logic          step;

  assign qual = bus.tick & bus.en;

  // Per-digit ripple of the advance condition; digits never share a binary carry.
  always_comb begin
    logic [DW-1:0] dig;
    logic [DW-1:0] lim;
    logic [DW-1:0] ld;
    step_val     = count_q;
    load_clamped = '0;
    adv          = '0;
    adv[0]       = 1'b1;
    for (int i = 0; i < NDIG; i++) begin
      dig = count_q[i*DW +: DW];
      lim = LIMS[i*DW +: DW];
      ld  = bus.load_val[i*DW +: DW];
      load_clamped[i*DW +: DW] = (ld > lim) ? lim : ld;
      if (bus.dir) begin
        adv[i+1] = adv[i] & (dig >= lim);
        if (adv[i])
          step_val[i*DW +: DW] = (dig >= lim) ? '0 : dig + DW'(1);
      end else begin
        adv[i+1] = adv[i] & (dig == '0);
        if (adv[i]) begin
          if (dig == '0)
            step_val[i*DW +: DW] = lim;
          else if (dig > lim)
            step_val[i*DW +: DW] = lim - DW'(1);
          else
            step_val[i*DW +: DW] = dig - DW'(1);
        end
      end
    end
  end

  assign carry_out = adv[NDIG];

`ifdef LCC_PRESCALE_EN
  localparam int PW = $clog2(PRESCALE + 1);
  logic [PW-1:0] presc_q;
  logic          presc_hit;

  assign presc_hit = (presc_q == PW'(PRESCALE - 1));
  assign step      = qual & presc_hit;

  always_ff @(posedge clk) begin
    if (reset || bus.load)
      presc_q <= '0;
    else if (qual)
      presc_q <= presc_hit ? '0 : presc_q + PW'(1);
  end
`else
  assign step = qual;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      co_q    <= 1'b0;
    end else if (bus.load) begin
      count_q <= load_clamped;
      co_q    <= 1'b0;
    end else if (step) begin
      co_q <= carry_out & bus.wrap;
      // Saturating at the terminal value simply holds the whole chain.
      if (!(carry_out && !bus.wrap))
        count_q <= step_val;
    end else begin
      co_q <= 1'b0;
    end
  end

  assign bus.count   = count_q;
  assign bus.co      = co_q;
  assign bus.at_term = bus.dir ? (count_q == LIMS) : (count_q == '0);

endmodule

// File: tb/tb_lim_counter_chain.sv
// Directed self-checking bench for lim_counter_chain (default LIMS=16'h5959).
module tb_lim_counter_chain;
  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  lim_counter_chain_if #(.NDIG(4), .DW(4)) bus ();

  lim_counter_chain #(
    .NDIG(4), .DW(4), .LIMS(16'h5959), .PRESCALE(4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.tick = 1'b0;
    bus.load = 1'b0;
  endtask

  task automatic do_load(input logic [15:0] v);
    bus.load     = 1'b1;
    bus.load_val = v;
    bus.tick     = 1'b0;
    cyc();
    bus.load     = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; bus.en = 1'b0; bus.tick = 1'b0; bus.dir = 1'b1;
    bus.wrap = 1'b1; bus.load = 1'b0; bus.load_val = '0;
    cyc(); cyc();
    reset = 1'b0;
    n_cmp++;
    if (bus.count !== 16'h0000) begin
      n_err++; $display("FAIL reset_count: got %h want 0000", bus.count);
    end
    n_cmp++;
    if (bus.co !== 1'b0) begin
      n_err++; $display("FAIL reset_co: got %b want 0", bus.co);
    end
  endtask

  task automatic test_up_count();
    int co_seen;
    co_seen = 0;
    bus.en = 1'b1; bus.dir = 1'b1; bus.wrap = 1'b1; bus.tick = 1'b1;
    for (int i = 0; i < 60; i++) begin
      cyc();
      if (bus.co === 1'b1) co_seen++;
    end
    idle();
    n_cmp++;
    if (bus.count !== 16'h0100) begin
      n_err++; $display("FAIL up60_count: got %h want 0100", bus.count);
    end
    n_cmp++;
    if (co_seen !== 0) begin
      n_err++; $display("FAIL up60_co: got %0d pulses want 0", co_seen);
    end
    n_cmp++;
    if (bus.at_term !== 1'b0) begin
      n_err++; $display("FAIL up60_at_term: got %b want 0", bus.at_term);
    end
  endtask

  task automatic test_wrap_up();
    bus.dir = 1'b1; bus.wrap = 1'b1;
    do_load(16'h5959);
    n_cmp++;
    if (bus.at_term !== 1'b1) begin
      n_err++; $display("FAIL wrapup_term_before: got %b want 1", bus.at_term);
    end
    bus.tick = 1'b1;
    cyc();
    idle();
    n_cmp++;
    if (bus.count !== 16'h0000 || bus.co !== 1'b1) begin
      n_err++; $display("FAIL wrapup_step: got count %h co %b want 0000 co 1", bus.count, bus.co);
    end
    n_cmp++;
    if (bus.at_term !== 1'b0) begin
      n_err++; $display("FAIL wrapup_term_after: got %b want 0", bus.at_term);
    end
    cyc();
    n_cmp++;
    if (bus.co !== 1'b0) begin
      n_err++; $display("FAIL wrapup_co_pulse: got %b want 0", bus.co);
    end
  endtask

  task automatic test_saturate();
    bus.dir = 1'b1; bus.wrap = 1'b0;
    do_load(16'h5959);
    bus.tick = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      n_cmp++;
      if (bus.count !== 16'h5959 || bus.co !== 1'b0 || bus.at_term !== 1'b1) begin
        n_err++;
        $display("FAIL sat_hold%0d: got count %h co %b term %b want 5959 co 0 term 1",
                 i, bus.count, bus.co, bus.at_term);
      end
    end
    idle();
    bus.dir = 1'b0;
    #1;
    n_cmp++;
    if (bus.at_term !== 1'b0) begin
      n_err++; $display("FAIL sat_term_dir: got %b want 0", bus.at_term);
    end
    bus.tick = 1'b1;
    cyc();
    idle();
    n_cmp++;
    if (bus.count !== 16'h5958) begin
      n_err++; $display("FAIL sat_reverse: got %h want 5958", bus.count);
    end
  endtask

  task automatic test_down();
    bus.dir = 1'b0; bus.wrap = 1'b1;
    do_load(16'h0100);
    bus.tick = 1'b1;
    cyc();
    idle();
    n_cmp++;
    if (bus.count !== 16'h0059 || bus.co !== 1'b0) begin
      n_err++; $display("FAIL down_borrow: got count %h co %b want 0059 co 0", bus.count, bus.co);
    end
    do_load(16'h0000);
    n_cmp++;
    if (bus.at_term !== 1'b1) begin
      n_err++; $display("FAIL down_term: got %b want 1", bus.at_term);
    end
    bus.tick = 1'b1;
    cyc();
    idle();
    n_cmp++;
    if (bus.count !== 16'h5959 || bus.co !== 1'b1) begin
      n_err++; $display("FAIL down_wrap: got count %h co %b want 5959 co 1", bus.count, bus.co);
    end
    cyc();
    n_cmp++;
    if (bus.co !== 1'b0) begin
      n_err++; $display("FAIL down_co_pulse: got %b want 0", bus.co);
    end
  endtask

  task automatic test_back_to_back();
    bus.dir = 1'b1; bus.wrap = 1'b1;
    do_load(16'h5959);
    bus.tick = 1'b1;
    cyc();
    n_cmp++;
    if (bus.count !== 16'h0000 || bus.co !== 1'b1) begin
      n_err++; $display("FAIL b2b_first: got count %h co %b want 0000 co 1", bus.count, bus.co);
    end
    bus.dir = 1'b0;
    cyc();
    idle();
    n_cmp++;
    if (bus.count !== 16'h5959 || bus.co !== 1'b1) begin
      n_err++; $display("FAIL b2b_second: got count %h co %b want 5959 co 1", bus.count, bus.co);
    end
  endtask

  task automatic test_load_clamp();
    bus.dir = 1'b1;
    do_load(16'hFFFF);
    n_cmp++;
    if (bus.count !== 16'h5959) begin
      n_err++; $display("FAIL clamp_ffff: got %h want 5959", bus.count);
    end
    do_load(16'h7A3B);
    n_cmp++;
    if (bus.count !== 16'h5939) begin
      n_err++; $display("FAIL clamp_mixed: got %h want 5939", bus.count);
    end
  endtask

  task automatic test_priority();
    bus.dir = 1'b1; bus.wrap = 1'b1;
    bus.load = 1'b1; bus.load_val = 16'h1234; bus.tick = 1'b1;
    cyc();
    idle();
    n_cmp++;
    if (bus.count !== 16'h1234) begin
      n_err++; $display("FAIL prio_load_tick: got %h want 1234", bus.count);
    end
    do_load(16'h5959);
    bus.tick = 1'b1;
    cyc();
    reset = 1'b1; bus.load = 1'b1; bus.load_val = 16'h4321; bus.tick = 1'b1;
    cyc();
    reset = 1'b0;
    idle();
    n_cmp++;
    if (bus.count !== 16'h0000 || bus.co !== 1'b0) begin
      n_err++; $display("FAIL prio_reset: got count %h co %b want 0000 co 0", bus.count, bus.co);
    end
  endtask

  task automatic test_enable();
    bus.dir = 1'b1; bus.wrap = 1'b1;
    do_load(16'h0005);
    bus.en = 1'b0; bus.tick = 1'b1;
    cyc(); cyc(); cyc();
    n_cmp++;
    if (bus.count !== 16'h0005 || bus.co !== 1'b0) begin
      n_err++; $display("FAIL en_hold: got count %h co %b want 0005 co 0", bus.count, bus.co);
    end
    bus.en = 1'b1;
    cyc();
    idle();
    n_cmp++;
    if (bus.count !== 16'h0006) begin
      n_err++; $display("FAIL en_resume: got %h want 0006", bus.count);
    end
  endtask

  task automatic test_prescale();
    bus.dir = 1'b1; bus.wrap = 1'b1; bus.en = 1'b1; bus.tick = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.en = (i == 3 || i == 6) ? 1'b0 : 1'b1;
      cyc();
    end
    idle();
    bus.en = 1'b1;
    n_cmp++;
    if (bus.count !== 16'h0002) begin
      n_err++; $display("FAIL presc_8ticks: got %h want 0002", bus.count);
    end
    bus.tick = 1'b1;
    cyc(); cyc();
    do_load(16'h0030);
    bus.tick = 1'b1;
    cyc(); cyc(); cyc();
    n_cmp++;
    if (bus.count !== 16'h0030) begin
      n_err++; $display("FAIL presc_after_load: got %h want 0030", bus.count);
    end
    cyc();
    idle();
    n_cmp++;
    if (bus.count !== 16'h0031) begin
      n_err++; $display("FAIL presc_fourth: got %h want 0031", bus.count);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
`ifdef LCC_PRESCALE_EN
    test_prescale();
`else
    test_up_count();
    test_wrap_up();
    test_saturate();
    test_down();
    test_back_to_back();
    test_load_clamp();
    test_priority();
    test_enable();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/lim_counter_chain.md
Name: lim_counter_chain

Overview:
- Cascaded chain of NDIG limited-increment digits, e.g. an mm:ss stopwatch or a BCD display counter.
- Each digit has its own limit and supports up/down counting, wrap or saturate mode, and synchronous load.
- Registered successor to the single-digit combinational limited incrementor.
- Feeds the seven-segment display driver directly and gets its step enable from the board tick generator.

Parameters:
- NDIG, 4, number of digits in the chain.
- DW, 4, width of each digit in bits.
- LIMS, 16'h5959, packed per-digit limits: digit i limit = LIMS[i*DW +: DW]. Digit 0 is the least significant. Each limit must be ≤ 2^DW-1.
- PRESCALE, 4, number of qualifying ticks per step. Used only when LCC_PRESCALE_EN is defined. Must be ≥ 1.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- en  in  1  count enable; a tick qualifies only when en=1.
- tick  in  1  step request; qualifying when tick&en.
- dir  in  1  1 = count up, 0 = count down.
- wrap  in  1  1 = wrap at terminal value, 0 = saturate at terminal value.
- load  in  1  synchronous load strobe.
- load_val  in  NDIG*DW  value to load, packed in the same layout as LIMS.
- count  out  NDIG*DW  registered counter value.
- co  out  1  registered one-cycle carry/borrow-out pulse.
- at_term  out  1  combinational from count; 1 when count equals the terminal value for the current dir.

Behaviour:
- Reset:
  - count=0, co=0, prescaler=0.
  - Reset has highest priority, including while load or tick is asserted.
- Priority per edge: reset > load > step > hold.
- Load:
  - count ← load_val, with each digit clamped to its limit (digit > lim loads lim).
  - co=0. Prescaler cleared.
- Step:
  - Occurs on an edge where a qualifying tick is sampled (see Optional Feature).
  - count and co update on that same edge, so latency is 1 clk.
- Digit rule, up:
  - A digit advances when all lower digits were at their limit before the step. Digit 0 always advances.
  - Advancing: digit==lim → 0 with carry; digit>lim is treated as lim (→0, carry); otherwise digit+1.
- Digit rule, down:
  - A digit advances when all lower digits were 0.
  - Advancing: digit==0 → lim with borrow; digit>lim → lim-1 (only reachable via forced state); otherwise digit-1.
- Terminal value:
  - Up: all digits == their limits. Down: all digits 0.
  - at_term = (count == terminal value for current dir).
- Terminal step with wrap=1: the chain wraps (up → all 0; down → all limits) and co=1 for exactly one cycle.
- Terminal step with wrap=0:
  - count holds and co stays 0.
  - at_term remains 1 until load, reset or a step in the opposite direction.
- co:
  - co=0 on every edge that is not a wrapping step.
  - Back-to-back wrapping steps give co high in consecutive cycles.
- Changing dir or wrap:
  - Takes effect on the next step; no internal state depends on them.
  - at_term changes combinationally with dir.
- en=0: tick is ignored; count, co=0 and the prescaler all hold.
- Arithmetic: per-digit, DW bits wide, with no cross-digit binary carry. The chain is not a plain binary counter.

Optional Feature:
- Macro: LCC_PRESCALE_EN.
- Defined:
  - An internal counter of $clog2(PRESCALE+1) bits counts qualifying ticks.
  - A step occurs on the PRESCALE-th qualifying tick; the prescaler then returns to 0.
  - The prescaler is cleared by reset and load. PRESCALE=1 behaves like the macro being undefined.
- Undefined: every qualifying tick is a step. PRESCALE is ignored and no prescaler logic exists.

Test Plan:
All scenarios use the defaults LIMS=16'h5959, NDIG=4, DW=4, macro undefined unless stated.
- Reset, then dir=1, wrap=1, en=1, 60 consecutive ticks → count=16'h0100. co never asserted. at_term=0.
- load 16'h5959, then one tick (dir=1, wrap=1) → count=16'h0000 with co=1 for exactly that cycle. at_term goes 1 then 0.
- load 16'h5959, wrap=0, dir=1, three ticks → count stays 16'h5959, co stays 0, at_term=1 throughout. Then set dir=0 and tick once → count=16'h5958.
- dir=0, wrap=1:
  - load 16'h0100, tick → 16'h0059.
  - load 16'h0000, tick → 16'h5959 with co=1 for one cycle.
- Load clamping and priority:
  - load 16'hFFFF → count=16'h5959.
  - load 16'h1234 with tick=1 in the same cycle → count=16'h1234 (load wins).
  - reset=1 with load=1 and tick=1 → count=0, co=0.
- LCC_PRESCALE_EN defined, PRESCALE=4:
  - 8 ticks with en toggled 0 on two extra cycles → count=16'h0002.
  - Load mid-prescale, then 3 ticks → count unchanged from the loaded value.
